ray_column_rasterizer: RTL

//  Expands per-column ray-cast results (column index, wall line height, wall type, side) into

---
 rtl/ray_column_rasterizer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ray_column_rasterizer.sv
// Expands one ray-cast column descriptor into SCREEN_HEIGHT pixel writes
// (ceiling / wall slice / floor), one pixel per clock. After a full frame of
// columns has been drawn it holds off new descriptors until the frame buffer swaps.
module ray_column_rasterizer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEIL_COLOR    = 16'h0000,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        dda_valid_in,
    output logic        dda_ready_out,
    input  logic [8:0]  dda_column_in,
    input  logic [7:0]  dda_line_height_in,
    input  logic [3:0]  dda_wall_type_in,
    input  logic        dda_wall_side_in,
    input  logic        fb_switched_in,
    output logic [15:0] ray_address_out,
    output logic [15:0] ray_pixel_out,
    output logic        ray_valid_out,
    output logic        ray_last_pixel_out
);

    localparam logic [7:0]  H_MAX    = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  ROW_LAST = 8'(SCREEN_HEIGHT - 1);
    localparam logic [8:0]  COL_LIM  = 9'(SCREEN_WIDTH);
    localparam logic [8:0]  COL_LAST = 9'(SCREEN_WIDTH - 1);
    localparam logic [15:0] ROW_STEP = 16'(SCREEN_WIDTH);

    typedef enum logic [1:0] {IDLE, DRAW, WAIT_SWAP} state_t;

    state_t      state_reg;
    logic [7:0]  row_reg;
    logic [8:0]  count_reg;
    logic [7:0]  start_reg;
    logic [7:0]  end_reg;
    logic [15:0] color_reg;

    logic [7:0]  h_clip;
    logic [7:0]  start_in;
    logic [7:0]  end_in;
    logic [15:0] color_in;
    logic        column_ok;
    logic        do_load;
    logic        last_row;
    logic        final_col;
    logic [7:0]  row_next;

    // Fixed wall palette, indexed by wall type (entry 0 is never drawn as a wall).
    function automatic logic [15:0] palette(input logic [3:0] idx);
        logic [15:0] c;
        case (idx)
            4'h0:    c = 16'h0000;
            4'h1:    c = 16'hF800;
            4'h2:    c = 16'h07E0;
            4'h3:    c = 16'h001F;
            4'h4:    c = 16'hFFE0;
            4'h5:    c = 16'hF81F;
            4'h6:    c = 16'h07FF;
            4'h7:    c = 16'hFFFF;
            4'h8:    c = 16'h8410;
            4'h9:    c = 16'hFC00;
            4'hA:    c = 16'h841F;
            4'hB:    c = 16'h07F0;
            4'hC:    c = 16'hA145;
            4'hD:    c = 16'h6B4D;
            4'hE:    c = 16'hC618;
            default: c = 16'h39E7;
        endcase
        return c;
    endfunction

    // Shaded side: each of R, G and B is halved independently so no bit leaks between fields.
    function automatic logic [15:0] shade(input logic [15:0] c, input logic side);
        return side ? {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]} : c;
    endfunction

    // Row classification against the wall slice [s, e).
    function automatic logic [15:0] pick(input logic [7:0] y, input logic [7:0] s,
                                         input logic [7:0] e, input logic [15:0] c);
        logic [15:0] p;
        if (y < s)      p = CEIL_COLOR;
        else if (y < e) p = c;
        else            p = FLOOR_COLOR;
        return p;
    endfunction

    // Slice geometry and colour for the descriptor currently offered, plus handshake decode.
    always_comb begin
        h_clip = (dda_line_height_in > H_MAX) ? H_MAX : dda_line_height_in;
        if (dda_wall_type_in == 4'd0) begin
            h_clip = 8'd0;
        end
        start_in  = (H_MAX - h_clip) >> 1;
        end_in    = start_in + h_clip;
        color_in  = shade(palette(dda_wall_type_in), dda_wall_side_in);
        column_ok = (dda_column_in < COL_LIM);
        last_row  = (row_reg == ROW_LAST);
        final_col = (count_reg == COL_LAST);
        row_next  = row_reg + 8'd1;
        // Ready while idle, and on the last row of a non-final column so columns chain without a bubble.
        dda_ready_out = (state_reg == IDLE) ||
                        ((state_reg == DRAW) && last_row && !final_col);
        do_load   = dda_valid_in && dda_ready_out && column_ok;
    end

    // Column sequencing, row/address stepping and registered pixel outputs.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg          <= IDLE;
            row_reg            <= 8'd0;
            count_reg          <= 9'd0;
            start_reg          <= 8'd0;
            end_reg            <= 8'd0;
            color_reg          <= 16'd0;
            ray_address_out    <= 16'd0;
            ray_pixel_out      <= 16'd0;
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ray_valid_out      <= 1'b0;
                    ray_last_pixel_out <= 1'b0;
                end
                DRAW: begin
                    if (last_row) begin
                        count_reg <= count_reg + 9'd1;
                        if (final_col) begin
                            ray_valid_out      <= 1'b0;
                            ray_last_pixel_out <= 1'b0;
                            state_reg          <= WAIT_SWAP;
                        end else begin
                            // Overridden below when a new column is loaded on this edge.
                            ray_valid_out <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end else begin
                        row_reg            <= row_next;
                        ray_address_out    <= ray_address_out + ROW_STEP;
                        ray_pixel_out      <= pick(row_next, start_reg, end_reg, color_reg);
                        ray_last_pixel_out <= (row_next == ROW_LAST) && final_col;
                    end
                end
                WAIT_SWAP: begin
                    // A swap pulse arriving while still drawing is deliberately lost.
                    if (fb_switched_in) begin
                        count_reg <= 9'd0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Out-of-range columns are consumed by the handshake but never loaded.
            if (do_load) begin
                state_reg          <= DRAW;
                row_reg            <= 8'd0;
                start_reg          <= start_in;
                end_reg            <= end_in;
                color_reg          <= color_in;
                ray_address_out    <= {7'd0, dda_column_in};
                ray_pixel_out      <= pick(8'd0, start_in, end_in, color_in);
                ray_valid_out      <= 1'b1;
                ray_last_pixel_out <= 1'b0;
            end
        end
    end

endmodule
